// File: rtl/arb_pkg.sv
// Shared constants for the two-port RAM arbiter: FSM states, port indices and request kinds.
package arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RDATA = 2'd2
   } state_e;

   localparam logic PORT_CPU = 1'b0;
   localparam logic PORT_DMA = 1'b1;

   typedef enum logic {
      READ  = 1'b0,
      WRITE = 1'b1
   } kind_e;

endpackage

// File: rtl/arb_port_slot.sv
// One pending-request slot: captures a strobe while idle and holds it until the arbiter
// clears it. A nonzero write mask always makes the request a write.
module arb_port_slot
   import arb_pkg::*;
#(
   parameter int unsigned ADDR_W = 32
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   input  logic [3:0]        wmask,
   input  logic              rstrb,
   input  logic              clear,
   output logic              busy,
   output logic [ADDR_W-1:0] slot_addr,
   output logic [31:0]       slot_wdata,
   output logic [3:0]        slot_wmask,
   output logic              slot_kind
);

   logic              busy_q;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       wdata_q;
   logic [3:0]        wmask_q;
   kind_e             kind_q;
   logic              strobe;

   assign strobe = rstrb | (|wmask);

   // Strobes arriving while busy, including the cycle the slot clears, are dropped.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         busy_q  <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         wmask_q <= '0;
         kind_q  <= READ;
      end else if (!busy_q && strobe) begin
         busy_q  <= 1'b1;
         addr_q  <= addr;
         wdata_q <= wdata;
         wmask_q <= wmask;
         kind_q  <= (|wmask) ? WRITE : READ;
      end else if (busy_q && clear) begin
         busy_q  <= 1'b0;
      end
   end

   assign busy       = busy_q;
   assign slot_addr  = addr_q;
   assign slot_wdata = wdata_q;
   assign slot_wmask = wmask_q;
   assign slot_kind  = kind_q;

endmodule

// File: rtl/ram_arbiter.sv
// Two-port RAM arbiter (CPU / DMA) serving one request at a time through IDLE/ISSUE/RDATA.
// Define ARB_FIXED_PRIO_EN to give port 0 fixed priority instead of round-robin.
module ram_arbiter
   import arb_pkg::*;
#(
   parameter int unsigned ADDR_W = 32
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [31:0]       m0_wdata,
   input  logic [3:0]        m0_wmask,
   input  logic              m0_rstrb,
   output logic [31:0]       m0_rdata,
   output logic              m0_busy,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [31:0]       m1_wdata,
   input  logic [3:0]        m1_wmask,
   input  logic              m1_rstrb,
   output logic [31:0]       m1_rdata,
   output logic              m1_busy,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [31:0]       ram_wdata,
   output logic [3:0]        ram_wmask,
   output logic              ram_rstrb,
   input  logic [31:0]       ram_rdata
);

   logic [1:0]        busy;
   logic [1:0]        slot_clear;
   logic [ADDR_W-1:0] slot_addr  [2];
   logic [31:0]       slot_wdata [2];
   logic [3:0]        slot_wmask [2];
   logic [1:0]        slot_kind;

   state_e      state_q, state_d;
   logic        grant_q, grant_d;
   logic        pick;
   logic [31:0] rdata0_q, rdata1_q;

   arb_port_slot #(.ADDR_W(ADDR_W)) u_slot0 (
      .clk        (clk),
      .resetn     (resetn),
      .addr       (m0_addr),
      .wdata      (m0_wdata),
      .wmask      (m0_wmask),
      .rstrb      (m0_rstrb),
      .clear      (slot_clear[PORT_CPU]),
      .busy       (busy[PORT_CPU]),
      .slot_addr  (slot_addr[PORT_CPU]),
      .slot_wdata (slot_wdata[PORT_CPU]),
      .slot_wmask (slot_wmask[PORT_CPU]),
      .slot_kind  (slot_kind[PORT_CPU])
   );

   arb_port_slot #(.ADDR_W(ADDR_W)) u_slot1 (
      .clk        (clk),
      .resetn     (resetn),
      .addr       (m1_addr),
      .wdata      (m1_wdata),
      .wmask      (m1_wmask),
      .rstrb      (m1_rstrb),
      .clear      (slot_clear[PORT_DMA]),
      .busy       (busy[PORT_DMA]),
      .slot_addr  (slot_addr[PORT_DMA]),
      .slot_wdata (slot_wdata[PORT_DMA]),
      .slot_wmask (slot_wmask[PORT_DMA]),
      .slot_kind  (slot_kind[PORT_DMA])
   );

`ifdef ARB_FIXED_PRIO_EN
   assign pick = busy[PORT_CPU] ? PORT_CPU : PORT_DMA;
`else
   logic last_q;

   // Reset value of last grant is DMA so the CPU wins the first tie.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         last_q <= PORT_DMA;
      end else if (state_q == ISSUE) begin
         last_q <= grant_q;
      end
   end

   assign pick = (&busy) ? ~last_q : (busy[PORT_CPU] ? PORT_CPU : PORT_DMA);
`endif

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q <= IDLE;
         grant_q <= PORT_CPU;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
      end
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      unique case (state_q)
         IDLE: begin
            if (|busy) begin
               state_d = ISSUE;
               grant_d = pick;
            end
         end
         ISSUE:   state_d = (slot_kind[grant_q] == WRITE) ? IDLE : RDATA;
         RDATA:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      ram_addr   = '0;
      ram_wdata  = '0;
      ram_wmask  = '0;
      ram_rstrb  = 1'b0;
      slot_clear = 2'b00;
      unique case (state_q)
         ISSUE: begin
            ram_addr            = slot_addr[grant_q];
            ram_wdata           = slot_wdata[grant_q];
            ram_wmask           = slot_wmask[grant_q];
            ram_rstrb           = (slot_kind[grant_q] == READ);
            slot_clear[grant_q] = (slot_kind[grant_q] == WRITE);
         end
         RDATA:   slot_clear[grant_q] = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         rdata0_q <= '0;
         rdata1_q <= '0;
      end else if (state_q == RDATA) begin
         if (grant_q == PORT_CPU) begin
            rdata0_q <= ram_rdata;
         end else begin
            rdata1_q <= ram_rdata;
         end
      end
   end

   assign m0_rdata = rdata0_q;
   assign m1_rdata = rdata1_q;
   assign m0_busy  = busy[PORT_CPU];
   assign m1_busy  = busy[PORT_DMA];

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed latency/reset cases plus randomized two-port traffic,
// checked by a request-queue model of the arbitration rules and a word-array RAM model.
module tb_ram_arbiter;

   localparam int unsigned AW = 32;

   logic          clk = 1'b0;
   logic          resetn;
   logic [AW-1:0] a_s [2];
   logic [31:0]   d_s [2];
   logic [3:0]    m_s [2];
   logic          r_s [2];
   logic [31:0]   m0_rdata, m1_rdata;
   logic          m0_busy, m1_busy;
   logic [AW-1:0] ram_addr;
   logic [31:0]   ram_wdata, ram_rdata;
   logic [3:0]    ram_wmask;
   logic          ram_rstrb;

   ram_arbiter #(.ADDR_W(AW)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .m0_addr   (a_s[0]),
      .m0_wdata  (d_s[0]),
      .m0_wmask  (m_s[0]),
      .m0_rstrb  (r_s[0]),
      .m0_rdata  (m0_rdata),
      .m0_busy   (m0_busy),
      .m1_addr   (a_s[1]),
      .m1_wdata  (d_s[1]),
      .m1_wmask  (m_s[1]),
      .m1_rstrb  (r_s[1]),
      .m1_rdata  (m1_rdata),
      .m1_busy   (m1_busy),
      .ram_addr  (ram_addr),
      .ram_wdata (ram_wdata),
      .ram_wmask (ram_wmask),
      .ram_rstrb (ram_rstrb),
      .ram_rdata (ram_rdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wmask;
      bit          wr;
      int unsigned t;
   } req_t;

   typedef struct {
      int unsigned due;
      bit          p;
      bit          wr;
      logic [31:0] rdata;
   } post_t;

   int          n_cmp = 0;
   int          n_bad = 0;
   int unsigned cyc = 0;
   bit          mon_en = 1'b0;
   bit          last_m = 1'b1;
   int          hits20 = 0;
   bit          mem_ok = 1'b0;
   bit          ref_ok = 1'b0;
   logic [31:0] mem [8];
   logic [31:0] ref_mem [8];
   req_t        pq0[$];
   req_t        pq1[$];
   post_t       post[$];

   function automatic logic [31:0] init_word(int i);
      return 32'hA5A50000 + 32'(i) + 32'h1;
   endfunction

   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // RAM: read data valid the cycle after the strobe, byte-masked writes.
   always @(posedge clk) begin
      if (!mem_ok) begin
         for (int i = 0; i < 8; i++) mem[i] <= init_word(i);
         mem_ok <= 1'b1;
      end else begin
         if (ram_rstrb) ram_rdata <= mem[ram_addr[4:2]];
         for (int b = 0; b < 4; b++)
            if (ram_wmask[b]) mem[ram_addr[4:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
      end
   end

   function automatic void model_reset();
      pq0.delete();
      pq1.delete();
      post.delete();
      last_m = 1'b1;
   endfunction

   // Reference: a request is eligible two cycles after its strobe; ties go to the port
   // not served last (or port 0 with fixed priority).
   function automatic void monitor_step();
      req_t       h;
      post_t      pc;
      bit         e0, e1, g;
      logic [2:0] idx;
      while (post.size() > 0 && post[0].due <= cyc) begin
         pc = post.pop_front();
         chk($sformatf("busy_low_p%0d", pc.p), pc.p ? m1_busy : m0_busy, 0);
         if (!pc.wr) chk($sformatf("rdata_p%0d", pc.p), pc.p ? m1_rdata : m0_rdata, pc.rdata);
      end
      if (ram_rstrb || ram_wmask != 4'h0) begin
         if (ram_addr == 32'h20) hits20++;
         e0 = pq0.size() > 0 && pq0[0].t + 2 <= cyc;
         e1 = pq1.size() > 0 && pq1[0].t + 2 <= cyc;
         if (!e0 && !e1) begin
            chk("unexpected_access", {ram_rstrb, ram_wmask}, 0);
         end else begin
`ifdef ARB_FIXED_PRIO_EN
            g = e0 ? 1'b0 : 1'b1;
`else
            g = (e0 && e1) ? ~last_m : (e0 ? 1'b0 : 1'b1);
`endif
            last_m = g;
            h = g ? pq1.pop_front() : pq0.pop_front();
            chk($sformatf("acc_addr_p%0d", g), ram_addr, h.addr);
            chk($sformatf("acc_wmask_p%0d", g), ram_wmask, h.wr ? h.wmask : 4'h0);
            chk($sformatf("acc_rstrb_p%0d", g), ram_rstrb, !h.wr);
            idx = h.addr[4:2];
            if (h.wr) begin
               chk($sformatf("acc_wdata_p%0d", g), ram_wdata, h.wdata);
               for (int b = 0; b < 4; b++)
                  if (h.wmask[b]) ref_mem[idx][8*b +: 8] = h.wdata[8*b +: 8];
            end
            pc.due   = cyc + (h.wr ? 1 : 2);
            pc.p     = g;
            pc.wr    = h.wr;
            pc.rdata = ref_mem[idx];
            post.push_back(pc);
         end
      end else begin
         chk("idle_addr", ram_addr, 0);
         chk("idle_wdata", ram_wdata, 0);
      end
   endfunction

   always @(negedge clk) begin
      if (!ref_ok) begin
         for (int i = 0; i < 8; i++) ref_mem[i] = init_word(i);
         ref_ok = 1'b1;
      end
      if (mon_en && resetn) monitor_step();
   end

   function automatic void put(int p, logic [31:0] a, logic [31:0] d, logic [3:0] m, logic r);
      req_t q;
      a_s[p] = a;
      d_s[p] = d;
      m_s[p] = m;
      r_s[p] = r;
      q.addr  = a;
      q.wdata = d;
      q.wmask = m;
      q.wr    = (m != 4'h0);
      q.t     = cyc;
      if (p == 0) pq0.push_back(q);
      else pq1.push_back(q);
   endfunction

   function automatic void idle_port(int p);
      m_s[p] = 4'h0;
      r_s[p] = 1'b0;
   endfunction

   task automatic drive(int p, logic [31:0] a, logic [31:0] d, logic [3:0] m, logic r);
      int t = 0;
      @(negedge clk);
      while ((p == 0 ? m0_busy : m1_busy) && t < 40) begin
         @(negedge clk);
         t++;
      end
      if (t >= 40) begin
         chk($sformatf("drive_timeout_p%0d", p), p == 0 ? m0_busy : m1_busy, 0);
      end else begin
         put(p, a, d, m, r);
         @(negedge clk);
         idle_port(p);
      end
   endtask

   task automatic rand_port(int p, int n, int max_gap);
      for (int i = 0; i < n; i++) begin
         logic [31:0] a = {27'd0, 3'($urandom_range(0, 7)), 2'b00};
         logic [3:0]  m = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
         logic        r = (m == 4'h0) ? 1'b1 : 1'($urandom);
         repeat ($urandom_range(0, max_gap)) @(negedge clk);
         drive(p, a, $urandom, m, r);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int t;
      resetn = 1'b0;
      for (int p = 0; p < 2; p++) begin
         a_s[p] = '0;
         d_s[p] = '0;
         idle_port(p);
      end
      repeat (3) @(negedge clk);
      chk("rst_m0_busy", m0_busy, 0);
      chk("rst_m1_busy", m1_busy, 0);
      chk("rst_m0_rdata", m0_rdata, 0);
      chk("rst_m1_rdata", m1_rdata, 0);
      chk("rst_ram_ctl", {ram_rstrb, ram_wmask}, 0);
      chk("rst_ram_addr", ram_addr, 0);
      resetn = 1'b1;
      model_reset();
      mon_en = 1'b1;

      // Port-0 write, uncontended.
      @(negedge clk); put(0, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0);
      @(negedge clk); idle_port(0);
      @(negedge clk);
      chk("t023_wmask", ram_wmask, 4'hF);
      chk("t023_addr", ram_addr, 32'h10);
      @(negedge clk); chk("t023_busy", m0_busy, 0);

      // Port-1 read back.
      @(negedge clk); put(1, 32'h10, 32'h0, 4'h0, 1'b1);
      @(negedge clk); idle_port(1);
      @(negedge clk); chk("t024_rstrb", ram_rstrb, 1);
      repeat (2) @(negedge clk);
      chk("t024_rdata", m1_rdata, 32'hDEADBEEF);
      chk("t024_busy", m1_busy, 0);

      // Simultaneous reads: port 0 first, port 1 three cycles later.
      @(negedge clk);
      put(0, 32'h0, 32'h0, 4'h0, 1'b1);
      put(1, 32'h4, 32'h0, 4'h0, 1'b1);
      @(negedge clk); idle_port(0); idle_port(1);
      @(negedge clk); chk("t025_p0_issue", {ram_rstrb, ram_addr}, {1'b1, 32'h0});
      repeat (3) @(negedge clk);
      chk("t025_p1_issue", {ram_rstrb, ram_addr}, {1'b1, 32'h4});
      repeat (3) @(negedge clk);

      // Strobe while busy must be ignored.
      @(negedge clk); put(0, 32'h8, 32'h0, 4'h0, 1'b1);
      @(negedge clk);
      chk("t028_busy", m0_busy, 1);
      a_s[0] = 32'h20;
      r_s[0] = 1'b1;
      @(negedge clk); idle_port(0);
      repeat (6) @(negedge clk);
      chk("t028_no_0x20", hits20, 0);
      chk("t028_busy_after", m0_busy, 0);

      // Reset during RDATA aborts the read.
      mon_en = 1'b0;
      @(negedge clk); put(0, 32'h4, 32'h0, 4'h0, 1'b1);
      @(negedge clk); idle_port(0);
      @(negedge clk); chk("t027_issue", ram_rstrb, 1);
      @(negedge clk); resetn = 1'b0;
      @(negedge clk);
      chk("t027_rdata", m0_rdata, 0);
      chk("t027_busy", m0_busy, 0);
      chk("t027_rstrb", ram_rstrb, 0);
      resetn = 1'b1;
      @(negedge clk);
      chk("t027_rdata_hold", m0_rdata, 0);
      chk("t027_idle", {ram_rstrb, ram_wmask}, 0);
      model_reset();
      mon_en = 1'b1;
      @(negedge clk); put(0, 32'h4, 32'hCAFE0123, 4'b0011, 1'b1);
      @(negedge clk); idle_port(0);
      @(negedge clk);
      chk("t027_wr_wmask", ram_wmask, 4'b0011);
      chk("t027_wr_rstrb", ram_rstrb, 0);
      @(negedge clk); chk("t027_wr_busy", m0_busy, 0);

      // Continuous re-strobing, then random gaps.
      fork
         rand_port(0, 20, 0);
         rand_port(1, 20, 0);
      join
      fork
         rand_port(0, 30, 3);
         rand_port(1, 30, 3);
      join

      t = 0;
      while ((pq0.size() + pq1.size() + post.size()) != 0 && t < 200) begin
         @(negedge clk);
         t++;
      end
      chk("drain_left", pq0.size() + pq1.size() + post.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
